// File: rtl/master_sequencer_pkg.sv
// Shared encodings for the master sequencer: FSM states, phase codes broadcast
// to the sub machines, display-machine status codes and fault codes.
package master_sequencer_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_ARM   = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_FAULT = 3'd5;

  localparam logic [1:0] MS_IDLE = 2'b00;
  localparam logic [1:0] MS_ARM  = 2'b01;
  localparam logic [1:0] MS_RUN  = 2'b11;
  localparam logic [1:0] MS_END  = 2'b10;

  localparam logic [3:0] SUB_DONE   = 4'hF;
  localparam logic [3:0] SUB_ILL_LO = 4'h9;
  localparam logic [3:0] SUB_ILL_HI = 4'hE;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_WDOG    = 2'b01;
  localparam logic [1:0] FC_ILLEGAL = 2'b10;

  function automatic logic [1:0] master_code(input logic [2:0] st);
    logic [1:0] code;
    case (st)
      ST_ARM:             code = MS_ARM;
      ST_RUN:             code = MS_RUN;
      ST_DONE, ST_FAULT:  code = MS_END;
      default:            code = MS_IDLE;
    endcase
    return code;
  endfunction

  function automatic logic sub_illegal(input logic [3:0] s);
    return (s >= SUB_ILL_LO) && (s <= SUB_ILL_HI);
  endfunction

endpackage

// File: rtl/master_sequencer_btn_sync.sv
// Button conditioner: two-flop synchroniser plus delay flop, rising-edge pulse.
// Edge pulse appears two CLK edges after the input rises; no backpressure.
module btn_sync_edge (
  input  logic CLK,
  input  logic RESET,
  input  logic btn,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/master_sequencer.sv
// Top-level sequencer for the LED display machine: clear, arm, run, done/fault.
// All outputs registered, changing with the state; inputs are never stalled.
module master_sequencer
  import master_sequencer_pkg::*;
#(
  parameter int SUB_RESET_CYCLES = 4,
  parameter int ARM_CYCLES       = 50000000,
  parameter int WDOG_CYCLES      = 60000000,
  parameter int CNT_W            = 27
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_START,
  input  logic       BTN_ABORT,
  input  logic [3:0] SUB_STATE,
  output logic [1:0] MASTER_STATE,
  output logic       SUB_RESET,
  output logic       BUSY,
  output logic       DONE,
  output logic [1:0] FAULT_CODE,
  output logic [7:0] RUN_COUNT
);

  localparam logic [CNT_W-1:0] SR_LAST   = CNT_W'(SUB_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);

  logic             start_e, abort_e;
  logic [2:0]       st, st_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ret_idle, ret_nxt;
  logic [3:0]       sub_prev;
  logic             sub_same;
  logic [1:0]       fc_nxt;
  logic [7:0]       rc_nxt;
  logic             undecoded;

  btn_sync_edge u_start (.CLK(CLK), .RESET(RESET), .btn(BTN_START), .rise(start_e));
  btn_sync_edge u_abort (.CLK(CLK), .RESET(RESET), .btn(BTN_ABORT), .rise(abort_e));

  assign sub_same = (SUB_STATE == sub_prev);

  always_comb begin
    st_nxt    = st;
    ret_nxt   = ret_idle;
    fc_nxt    = FAULT_CODE;
    rc_nxt    = RUN_COUNT;
    undecoded = 1'b0;
    case (st)
      ST_IDLE: begin
        if (start_e) begin
          st_nxt  = ST_CLEAR;
          ret_nxt = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (cnt == SR_LAST) st_nxt = ret_idle ? ST_IDLE : ST_ARM;
      end
      ST_ARM: begin
        if (abort_e) begin
          st_nxt  = ST_CLEAR;
          ret_nxt = 1'b1;
        end else if (cnt == ARM_LAST) begin
          st_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // abort outranks every status the display machine reports
        if (abort_e) begin
          st_nxt  = ST_CLEAR;
          ret_nxt = 1'b1;
        end else if (sub_illegal(SUB_STATE)) begin
          st_nxt = ST_FAULT;
          fc_nxt = FC_ILLEGAL;
        end else if (SUB_STATE == SUB_DONE) begin
          st_nxt = ST_DONE;
          rc_nxt = (RUN_COUNT == 8'hFF) ? RUN_COUNT : RUN_COUNT + 8'd1;
        end else if (sub_same && cnt == WDOG_LAST) begin
          st_nxt = ST_FAULT;
          fc_nxt = FC_WDOG;
        end
      end
      ST_DONE, ST_FAULT: begin
        if (abort_e) begin
          st_nxt  = ST_CLEAR;
          ret_nxt = 1'b1;
        end else if (start_e) begin
          st_nxt  = ST_CLEAR;
          ret_nxt = 1'b0;
        end
      end
      default: begin
        st_nxt    = ST_IDLE;
        undecoded = 1'b1;
      end
    endcase

    if (st_nxt == ST_CLEAR && st != ST_CLEAR) fc_nxt = FC_NONE;

    // one counter serves as phase timer in CLEAR/ARM and stall watchdog in RUN
    if (st_nxt != st)
      cnt_nxt = '0;
    else if (st == ST_RUN)
      cnt_nxt = sub_same ? cnt + CNT_W'(1) : '0;
    else if (st == ST_CLEAR || st == ST_ARM)
      cnt_nxt = cnt + CNT_W'(1);
    else
      cnt_nxt = '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      st           <= ST_IDLE;
      cnt          <= '0;
      ret_idle     <= 1'b0;
      sub_prev     <= 4'h0;
      MASTER_STATE <= MS_IDLE;
      SUB_RESET    <= 1'b1;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      FAULT_CODE   <= FC_NONE;
      RUN_COUNT    <= 8'd0;
    end else begin
      st           <= st_nxt;
      cnt          <= cnt_nxt;
      ret_idle     <= ret_nxt;
      sub_prev     <= SUB_STATE;
      MASTER_STATE <= master_code(st_nxt);
      SUB_RESET    <= (st_nxt == ST_CLEAR) | undecoded;
      BUSY         <= (st_nxt == ST_CLEAR) | (st_nxt == ST_ARM) | (st_nxt == ST_RUN);
      DONE         <= (st_nxt == ST_DONE);
      FAULT_CODE   <= fc_nxt;
      RUN_COUNT    <= rc_nxt;
    end
  end

endmodule
